mux_scan: RTL
=============

Name: mux_scan

Overview:
Parametrised N:1 registered data multiplexer, successor to the 2:1 combinational mux. Channel selection is either manual (external `sel`) or automatic round-robin scanning with a programmable dwell time per channel. Output is registered, tagged with the active channel index, and accompanied by channel-change and scan-complete strobes. Used as the front-end channel selector ahead of display, UART and logging blocks.

Parameters:
CH_NUM, 4, number of input channels; legal range 2..16.
DATA_W, 8, width of each channel in bits.
DWELL, 50, clock cycles spent on each channel in auto mode; legal range 1..2^16-1.
(local) SEL_W = $clog2(CH_NUM); dwell counter width = $clog2(DWELL+1).

Ports:
Clk  input  1  system clock; all logic on rising edge.
Reset_n  input  1  synchronous, active-low reset.
din  input  CH_NUM*DATA_W  packed channel data; channel k at bits [k*DATA_W +: DATA_W].
sel  input  SEL_W  manual channel select; used only when mode=0.
mode  input  1  0 = manual select, 1 = auto scan.
hold  input  1  auto mode only: 1 freezes dwell counter and channel pointer.
out  output  DATA_W  registered selected data.
out_ch  output  SEL_W  index of the channel currently on `out`.
ch_start  output  1  one-cycle pulse, high in the first cycle `out` reflects a new channel.
scan_done  output  1  one-cycle pulse, coincident with `ch_start` when auto scan wraps to channel 0.

Behaviour:
- Reset (Reset_n=0 at an edge): ptr=0, dwell_cnt=0, out=0, out_ch=0, ch_start=0, scan_done=0. Applies mid-scan; scanning resumes from channel 0 with a fresh dwell after release.
- Internal `ptr_nxt` is computed combinationally each cycle. At every edge: ptr<=ptr_nxt; out<=din[ptr_nxt]; out_ch<=ptr_nxt; ch_start<=(ptr_nxt!=ptr).
- Latency: one cycle from `sel`/`din` change to `out`. `out` samples `din` of the active channel every cycle, including while held.
- Manual (mode=0): ptr_nxt=sel if sel<CH_NUM; otherwise ptr_nxt=ptr (illegal select ignored, no pulse). dwell_cnt held at 0. scan_done=0.
- Auto (mode=1, hold=0): dwell_cnt counts 0..DWELL-1. When dwell_cnt=DWELL-1: dwell_cnt<=0 and ptr_nxt=ptr+1, wrapping CH_NUM-1 -> 0; otherwise ptr_nxt=ptr. scan_done<=1 on the edge where ptr wraps to 0, else 0.
- Each channel occupies `out` for exactly DWELL cycles. DWELL=1 advances every cycle, so `ch_start` stays high continuously.
- Auto with hold=1: dwell_cnt and ptr frozen, no pulses. Releasing hold continues the count from its frozen value.
- Mode 0->1: scan starts from the current ptr, dwell_cnt cleared, first advance after DWELL cycles.
- Mode 1->0: ptr_nxt=sel (legality rule applies), dwell_cnt cleared.
- hold is ignored in manual mode.
- ch_start and scan_done are never asserted in the cycle immediately after reset unless ptr_nxt!=0.

Test Plan:
CH_NUM=4, DATA_W=8, DWELL=4, din={8'h44,8'h33,8'h22,8'h11} for all tests.
1. Reset_n=0 for 3 cycles while mode=1 -> out=0, out_ch=0, no pulses. Release with mode=0, sel=0 -> out=8'h11 after 1 cycle, ch_start stays 0.
2. Manual, sel steps 0,1,2,3 at 5-cycle spacing -> out = 11,22,33,44 each one cycle after sel change. ch_start pulses once per change. Repeat with a 3-bit sel test variant of CH_NUM=5 at sel=7 -> out holds, no pulse.
3. Auto, hold=0, run 20 cycles -> out sequence 11x4, 22x4, 33x4, 44x4, 11x4. ch_start every 4 cycles. scan_done only at the 44->11 transition.
4. Auto, assert hold for 6 cycles mid-channel 2 after 2 dwell cycles -> out=33 for 2+6+2 cycles total, then 44. din[2] changed to 8'hA5 during hold appears on out after 1 cycle.
5. Auto on channel 3, switch mode=0 with sel=1 -> out=22 next cycle with ch_start=1, scan_done=0. Switch back to mode=1 -> channel 1 held for 4 cycles, then 2.
6. Reset_n pulsed low for 1 cycle during auto on channel 2 -> out=0, out_ch=0 next cycle. After release, out=11 for a full 4-cycle dwell.

Source files
------------

// File: rtl/mux_scan.sv
// Purpose : N:1 registered channel selector, manual select or round-robin auto scan with per-channel dwell.
// Latency : one cycle from sel/din to out; out_ch, ch_start and scan_done are registered alongside out.
// Backpressure: none; hold freezes the auto scan, and out keeps sampling the active channel every cycle.
//
// Ports:
//   Clk, Reset_n      rising-edge clock, synchronous active-low reset
//   din               packed channel data, channel k at [k*DATA_W +: DATA_W]
//   sel               manual channel select, used when mode=0 (out-of-range values ignored)
//   mode              0 = manual, 1 = auto scan
//   hold              auto mode only: freeze dwell counter and channel pointer
//   out, out_ch       registered data of the active channel and its index
//   ch_start          one-cycle pulse in the first cycle out shows a new channel
//   scan_done         one-cycle pulse with ch_start when the auto scan wraps to channel 0
module mux_scan #(
    parameter int CH_NUM = 4,               // 2..16
    parameter int DATA_W = 8,
    parameter int DWELL  = 50,              // 1..65535
    localparam int SEL_W = $clog2(CH_NUM),
    localparam int CNT_W = $clog2(DWELL + 1)
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [CH_NUM*DATA_W-1:0] din,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    input  logic                     hold,
    output logic [DATA_W-1:0]        out,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     ch_start,
    output logic                     scan_done
);

    localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CH_NUM);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CH_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  ptr_nxt;
    logic [CNT_W-1:0]  dwell_cnt;
    logic [CNT_W-1:0]  dwell_cnt_nxt;
    logic              scan_done_nxt;
    logic [DATA_W-1:0] sel_dat;

    // Low in the first cycle after reset release. That cycle still shows the
    // reset value on out, so it is not charged to channel 0's dwell; this way
    // channel 0 gets a full DWELL cycles on out after a reset, like every
    // other channel.
    logic              run;

    always_comb begin
        ptr_nxt       = ptr;
        dwell_cnt_nxt = dwell_cnt;
        scan_done_nxt = 1'b0;
        if (!mode) begin
            // Manual: the dwell counter idles at 0, so entering auto mode
            // always starts a fresh dwell on the current channel.
            dwell_cnt_nxt = '0;
            if ({1'b0, sel} < CH_LIM) begin
                ptr_nxt = sel;
            end
        end else if (!hold && run) begin
            if (dwell_cnt == CNT_LAST) begin
                dwell_cnt_nxt = '0;
                if (ptr == PTR_LAST) begin
                    ptr_nxt       = '0;
                    scan_done_nxt = 1'b1;
                end else begin
                    ptr_nxt = ptr + SEL_W'(1);
                end
            end else begin
                dwell_cnt_nxt = dwell_cnt + CNT_W'(1);
            end
        end
    end

    // Select on ptr_nxt so out, out_ch and ch_start all update on the same edge.
    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (ptr_nxt == SEL_W'(k)) begin
                sel_dat = din[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ptr       <= '0;
            dwell_cnt <= '0;
            run       <= 1'b0;
            out       <= '0;
            out_ch    <= '0;
            ch_start  <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            run       <= 1'b1;
            out       <= sel_dat;
            out_ch    <= ptr_nxt;
            ch_start  <= (ptr_nxt != ptr);
            scan_done <= scan_done_nxt;
        end
    end

endmodule
